// File: rtl/piano_pkg.sv
// Shared definitions for the note-player path: allocator states, width helpers, defaults.
package piano_pkg;

  localparam int unsigned DEF_NOTE_W   = 8;
  localparam int unsigned DEF_PERIOD_W = 13;
  localparam int unsigned MAX_VOICES   = 16;
  localparam int unsigned MAX_IDX_W    = $clog2(MAX_VOICES);

  typedef enum logic [1:0] {
    ALLOC_IDLE  = 2'd0,
    ALLOC_SCAN  = 2'd1,
    ALLOC_APPLY = 2'd2
  } allocState_t;

  // Width of a voice index / carrier counter (at least one bit).
  function automatic int unsigned idxWidth(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Width able to hold a count of 0..n (popcount of n phase bits).
  function automatic int unsigned cntWidth(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/poly_note_player_tone_voice.sv
// Single square-wave tone voice: holds note key, half-period, counter and phase.
module tone_voice
  import piano_pkg::*;
#(
  parameter int unsigned NOTE_W   = DEF_NOTE_W,
  parameter int unsigned PERIOD_W = DEF_PERIOD_W
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic                iLoad,
  input  logic                iClear,
  input  logic [NOTE_W-1:0]   iNote,
  input  logic [PERIOD_W-1:0] iHalfPeriod,
  output logic                oActive,
  output logic [NOTE_W-1:0]   oNote,
  output logic                oPhase
);

  logic [PERIOD_W-1:0] halfPeriod;
  logic [PERIOD_W-1:0] counter;

  // Load/clear from the allocator take priority; otherwise an active voice counts and toggles.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      oActive    <= 1'b0;
      oNote      <= '0;
      halfPeriod <= '0;
      counter    <= '0;
      oPhase     <= 1'b0;
    end else if (iLoad) begin
      oActive    <= 1'b1;
      oNote      <= iNote;
      halfPeriod <= iHalfPeriod;
      counter    <= '0;
      oPhase     <= 1'b0;
    end else if (iClear) begin
      oActive <= 1'b0;
      counter <= '0;
      oPhase  <= 1'b0;
    end else if (oActive) begin
      if (counter == halfPeriod - PERIOD_W'(1)) begin
        counter <= '0;
        oPhase  <= ~oPhase;
      end else begin
        counter <= counter + PERIOD_W'(1);
      end
    end
  end

endmodule

// File: rtl/poly_note_player.sv
// Polyphonic note player: event allocator FSM over NUM_VOICES tone voices plus PWM mixer.
module poly_note_player
  import piano_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned NOTE_W     = DEF_NOTE_W,
  parameter int unsigned PERIOD_W   = DEF_PERIOD_W,
  parameter bit          STEAL      = 1'b1
) (
  input  logic                  iClk,
  input  logic                  iReset_n,
  input  logic                  iEvtValid,
  output logic                  oEvtReady,
  input  logic                  iEvtOn,
  input  logic [NOTE_W-1:0]     iEvtNote,
  input  logic [PERIOD_W-1:0]   iEvtHalfPeriod,
  output logic [NUM_VOICES-1:0] oActive,
  output logic                  oDropped,
  output logic                  oPWM
);

  localparam int unsigned IDX_W = idxWidth(NUM_VOICES);
  localparam int unsigned HC_W  = cntWidth(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  allocState_t state, nextState;

  logic [IDX_W-1:0]    idx;
  logic                evtOn;
  logic [NOTE_W-1:0]   evtNote;
  logic [PERIOD_W-1:0] evtHp;
  logic                matchFound, freeFound;
  logic [IDX_W-1:0]    matchIdx, freeIdx, stealPtr;

  logic                doLoad, doClear, stealAdv, dropNow;
  logic [IDX_W-1:0]    tgtIdx;

  logic [NUM_VOICES-1:0] voiceActive, voicePhase, voiceLoad, voiceClear;
  logic [NOTE_W-1:0]     voiceNote [NUM_VOICES];

  logic [IDX_W-1:0] carrier;
  logic [HC_W-1:0]  phaseCount, highCount;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : gVoice
    assign voiceLoad[g]  = doLoad  && (tgtIdx == IDX_W'(g));
    assign voiceClear[g] = doClear && (tgtIdx == IDX_W'(g));

    tone_voice #(
      .NOTE_W  (NOTE_W),
      .PERIOD_W(PERIOD_W)
    ) uVoice (
      .iClk       (iClk),
      .iReset_n   (iReset_n),
      .iLoad      (voiceLoad[g]),
      .iClear     (voiceClear[g]),
      .iNote      (evtNote),
      .iHalfPeriod(evtHp),
      .oActive    (voiceActive[g]),
      .oNote      (voiceNote[g]),
      .oPhase     (voicePhase[g])
    );
  end

  assign oActive   = voiceActive;
  assign oEvtReady = (state == ALLOC_IDLE);
  assign oDropped  = dropNow;

  // Allocator state register.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state <= ALLOC_IDLE;
    else           state <= nextState;
  end

  // Allocator next-state: accept in IDLE, one voice per SCAN cycle, single APPLY cycle.
  always_comb begin
    nextState = state;
    unique case (state)
      ALLOC_IDLE:  if (iEvtValid) nextState = ALLOC_SCAN;
      ALLOC_SCAN:  if (idx == LAST_IDX) nextState = ALLOC_APPLY;
      ALLOC_APPLY: nextState = ALLOC_IDLE;
      default:     nextState = ALLOC_IDLE;
    endcase
  end

  // APPLY decision: retrigger match, else claim lowest free, else steal or drop; key-off clears match.
  always_comb begin
    doLoad   = 1'b0;
    doClear  = 1'b0;
    stealAdv = 1'b0;
    dropNow  = 1'b0;
    tgtIdx   = '0;
    if (state == ALLOC_APPLY) begin
      if (evtOn) begin
        if (evtHp != '0) begin
          if (matchFound) begin
            doLoad = 1'b1;
            tgtIdx = matchIdx;
          end else if (freeFound) begin
            doLoad = 1'b1;
            tgtIdx = freeIdx;
          end else if (STEAL) begin
            doLoad   = 1'b1;
            tgtIdx   = stealPtr;
            stealAdv = 1'b1;
          end else begin
            dropNow = 1'b1;
          end
        end
      end else if (matchFound) begin
        doClear = 1'b1;
        tgtIdx  = matchIdx;
      end
    end
  end

  // Event latch, per-cycle voice scan (first match / first free win) and steal pointer.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      idx        <= '0;
      evtOn      <= 1'b0;
      evtNote    <= '0;
      evtHp      <= '0;
      matchFound <= 1'b0;
      matchIdx   <= '0;
      freeFound  <= 1'b0;
      freeIdx    <= '0;
      stealPtr   <= '0;
    end else begin
      unique case (state)
        ALLOC_IDLE: begin
          if (iEvtValid) begin
            evtOn      <= iEvtOn;
            evtNote    <= iEvtNote;
            evtHp      <= iEvtHalfPeriod;
            idx        <= '0;
            matchFound <= 1'b0;
            freeFound  <= 1'b0;
          end
        end
        ALLOC_SCAN: begin
          if (!matchFound && voiceActive[idx] && (voiceNote[idx] == evtNote)) begin
            matchFound <= 1'b1;
            matchIdx   <= idx;
          end
          if (!freeFound && !voiceActive[idx]) begin
            freeFound <= 1'b1;
            freeIdx   <= idx;
          end
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
      if (stealAdv) stealPtr <= (stealPtr == LAST_IDX) ? '0 : stealPtr + IDX_W'(1);
    end
  end

  // Count phase bits currently high.
  always_comb begin
    phaseCount = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) phaseCount += HC_W'(voicePhase[i]);
  end

  // Mixer: wrapping carrier compared against registered popcount.
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      carrier   <= '0;
      highCount <= '0;
      oPWM      <= 1'b0;
    end else begin
      carrier   <= (carrier == LAST_IDX) ? '0 : carrier + IDX_W'(1);
      highCount <= phaseCount;
      oPWM      <= (HC_W'(carrier) < highCount);
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// Self-checking bench: two instances (steal / drop) driven with the same events, checked against a voice-table model.
module tb_poly_note_player;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          evtValid = 1'b0;
  logic          evtOn = 1'b0;
  logic [7:0]    evtNote = '0;
  logic [12:0]   evtHp = '0;
  logic          ready1, ready0, drop1, drop0, pwm1, pwm0;
  logic [NV-1:0] act1, act0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int lastUpd = 0;
  bit pwmCheck = 1'b0;

  // Model: per instance (0 = steal, 1 = drop) a table of voices with the edge they were (re)started.
  bit   mAct  [2][NV];
  logic [7:0] mNote [2][NV];
  int   mHp   [2][NV];
  int   mLoad [2][NV];
  int   mPtr  [2];

  always #5 clk = ~clk;

  poly_note_player #(.NUM_VOICES(NV), .NOTE_W(8), .PERIOD_W(13), .STEAL(1'b1)) dutSteal (
    .iClk(clk), .iReset_n(rstN), .iEvtValid(evtValid), .oEvtReady(ready1), .iEvtOn(evtOn),
    .iEvtNote(evtNote), .iEvtHalfPeriod(evtHp), .oActive(act1), .oDropped(drop1), .oPWM(pwm1));

  poly_note_player #(.NUM_VOICES(NV), .NOTE_W(8), .PERIOD_W(13), .STEAL(1'b0)) dutDrop (
    .iClk(clk), .iReset_n(rstN), .iEvtValid(evtValid), .oEvtReady(ready0), .iEvtOn(evtOn),
    .iEvtNote(evtNote), .iEvtHalfPeriod(evtHp), .oActive(act0), .oDropped(drop0), .oPWM(pwm0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popAt(input int m, input int j);
    int s = 0;
    for (int v = 0; v < NV; v++)
      if (mAct[m][v]) s += ((j - mLoad[m][v]) / mHp[m][v]) % 2;
    return s;
  endfunction

  function automatic logic [NV-1:0] expAct(input int m);
    logic [NV-1:0] r = '0;
    for (int v = 0; v < NV; v++) r[v] = mAct[m][v];
    return r;
  endfunction

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      mPtr[m] = 0;
      for (int v = 0; v < NV; v++) begin
        mAct[m][v] = 1'b0; mNote[m][v] = '0; mHp[m][v] = 1; mLoad[m][v] = 0;
      end
    end
  endtask

  task automatic modelEvent(input int m, input bit on, input logic [7:0] note, input int hp,
                            input int e, output bit drop);
    int match = -1;
    int free = -1;
    int t = -1;
    drop = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (match < 0 && mAct[m][v] && mNote[m][v] == note) match = v;
      if (free < 0 && !mAct[m][v]) free = v;
    end
    if (on) begin
      if (hp != 0) begin
        if (match >= 0) t = match;
        else if (free >= 0) t = free;
        else if (m == 0) begin t = mPtr[m]; mPtr[m] = (mPtr[m] + 1) % NV; end
        else drop = 1'b1;
        if (t >= 0) begin
          mAct[m][t] = 1'b1; mNote[m][t] = note; mHp[m][t] = hp; mLoad[m][t] = e;
        end
      end
    end else if (match >= 0) begin
      mAct[m][match] = 1'b0;
    end
  endtask

  // One clock; PWM of both instances compared to the model whenever the model history is settled.
  task automatic tick();
    @(posedge clk);
    if (rstN) cyc++;
    #1;
    if (pwmCheck && cyc >= 2 && cyc - 2 >= lastUpd) begin
      check("pwmSteal", pwm1, (((cyc - 1) % NV) < popAt(0, cyc - 2)) ? 1 : 0);
      check("pwmDrop",  pwm0, (((cyc - 1) % NV) < popAt(1, cyc - 2)) ? 1 : 0);
    end
  endtask

  task automatic sendEvt(input bit on, input logic [7:0] note, input int hp, input bit keepValid,
                         output int xEdge);
    bit d0, d1;
    int guard = 0;
    int e;
    evtOn = on; evtNote = note; evtHp = hp[12:0]; evtValid = 1'b1;
    while (!ready1 && guard < 40) begin tick(); guard++; end
    check("readyWait", (guard < 40) ? 1 : 0, 1);
    tick();
    xEdge = cyc;
    if (!keepValid) evtValid = 1'b0;
    e = xEdge + NV + 1;
    modelEvent(0, on, note, hp, e, d0);
    modelEvent(1, on, note, hp, e, d1);
    lastUpd = e;
    for (int i = 0; i < NV; i++) begin
      check("readyLowSteal", ready1, 0);
      check("readyLowDrop", ready0, 0);
      check("dropScan", {drop1, drop0}, 0);
      tick();
    end
    check("readyLowApply", {ready1, ready0}, 0);
    check("dropApplySteal", drop1, d0);
    check("dropApplyDrop", drop0, d1);
    tick();
    check("readyBack", {ready1, ready0}, 2'b11);
    check("dropGone", {drop1, drop0}, 0);
    check("activeSteal", act1, expAct(0));
    check("activeDrop", act0, expAct(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int x, xPrev;
    modelReset();
    // Reset state
    tick(); tick();
    check("rstReady", {ready1, ready0}, 2'b11);
    check("rstActive", {act1, act0}, 0);
    check("rstDrop", {drop1, drop0}, 0);
    check("rstPwm", {pwm1, pwm0}, 0);
    rstN = 1'b1; cyc = 0; lastUpd = 0; pwmCheck = 1'b1;

    // Single voice, half-period 3
    sendEvt(1'b1, 8'h15, 3, 1'b0, x);
    idle(14);
    sendEvt(1'b0, 8'h15, 0, 1'b0, x);

    // Fill all voices, free one, reclaim it
    for (int n = 1; n <= 4; n++) sendEvt(1'b1, 8'(n), $urandom_range(1, 7), 1'b0, x);
    idle(8);
    sendEvt(1'b0, 8'd3, 0, 1'b0, x);
    sendEvt(1'b1, 8'd9, 2, 1'b0, x);
    idle(10);

    // Retrigger voice 0 with a 5-clock half-period
    sendEvt(1'b1, 8'd1, 5, 1'b0, x);
    idle(16);

    // All busy: steal (0 then 1) vs drop; pointer position shown by the next steal
    sendEvt(1'b1, 8'd7, 4, 1'b0, x);
    sendEvt(1'b1, 8'd8, 1, 1'b0, x);
    idle(6);
    sendEvt(1'b1, 8'd10, 3, 1'b0, x);
    sendEvt(1'b0, 8'd10, 0, 1'b0, x);
    idle(6);

    // Unused key-off and zero half-period key-on: no state change, no drop
    sendEvt(1'b0, 8'h40, 0, 1'b0, x);
    sendEvt(1'b1, 8'h41, 0, 1'b0, x);
    idle(6);

    // Randomized events
    for (int r = 0; r < 24; r++) begin
      sendEvt(($urandom_range(0, 3) != 0), 8'($urandom_range(1, 6)), $urandom_range(0, 6), 1'b0, x);
      idle($urandom_range(0, 6));
    end

    // Valid held high: transfers exactly NV+2 apart
    sendEvt(1'b1, 8'd20, 2, 1'b1, xPrev);
    sendEvt(1'b0, 8'd20, 0, 1'b1, x);
    check("holdSpacing1", x - xPrev, NV + 2);
    xPrev = x;
    sendEvt(1'b1, 8'd21, 1, 1'b0, x);
    check("holdSpacing2", x - xPrev, NV + 2);
    idle(8);

    // Reset asserted mid-SCAN
    pwmCheck = 1'b0;
    evtOn = 1'b1; evtNote = 8'd30; evtHp = 13'd2; evtValid = 1'b1;
    tick();
    evtValid = 1'b0;
    tick(); tick();
    check("midScanBusy", ready1, 0);
    #2 rstN = 1'b0;
    #1;
    check("abortReady", {ready1, ready0}, 2'b11);
    check("abortActive", {act1, act0}, 0);
    check("abortDrop", {drop1, drop0}, 0);
    check("abortPwm", {pwm1, pwm0}, 0);
    tick();
    rstN = 1'b1; cyc = 0; lastUpd = 0; modelReset(); pwmCheck = 1'b1;
    for (int i = 0; i < NV + 3; i++) begin
      tick();
      check("noPartialUpdate", {act1, act0}, 0);
      check("noPartialReady", {ready1, ready0}, 2'b11);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
